// File: rtl/queue_arbiter.sv
// queue_arbiter: four-requester round-robin push arbiter in front of a
// 16-entry ring-buffer FIFO with a single registered pop port.
module queue_arbiter #(
  parameter int DW   = 8,
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      push_req,
  input  logic [NREQ*DW-1:0]   push_data,
  output logic [NREQ-1:0]      push_gnt,
  input  logic                 pop,
  output logic [DW-1:0]        pop_data,
  output logic                 pop_valid,
  output logic [4:0]           size,
  output logic [15:0]          valid,
  output logic                 full,
  output logic                 empty
);

  logic [DW-1:0] mem [16];
  logic [3:0]    front;
  logic [4:0]    cnt;
  logic [1:0]    last;

  logic [NREQ-1:0] gnt;
  logic [1:0]      gidx;
  logic [1:0]      idx;
  logic            found;
  logic [DW-1:0]   wdata;
  logic            push_ok;
  logic            pop_ok;
  logic [3:0]      tail;
  logic [3:0]      off;

  // Round-robin search starting one past the last winner; gated off in reset or when full
  always_comb begin
    gnt   = '0;
    gidx  = last;
    idx   = '0;
    found = 1'b0;
    if (rst && (cnt != 5'd16)) begin
      for (int unsigned k = 1; k <= 4; k++) begin
        idx = last + 2'(k);
        if (!found && push_req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gidx     = idx;
        end
      end
    end
  end

  // Select the granted requester's entry
  always_comb begin
    wdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (gnt[i]) begin
        wdata = push_data[i*DW +: DW];
      end
    end
  end

  assign push_gnt = gnt;
  assign push_ok  = |gnt;
  assign pop_ok   = pop && (cnt != 5'd0);
  assign tail     = front + cnt[3:0];

  // Storage write at the tail slot; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= wdata;
    end
  end

  // Pointer, occupancy, arbitration history and registered pop output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front     <= '0;
      cnt       <= '0;
      last      <= 2'd3;
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      pop_valid <= pop_ok;
      if (pop_ok) begin
        pop_data <= mem[front];
        front    <= front + 4'd1;
      end
      if (push_ok) begin
        last <= gidx;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Slot i is live when its distance from front (mod 16) is below the count
  always_comb begin
    valid = '0;
    off   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      off      = 4'(i) - front;
      valid[i] = ({1'b0, off} < cnt);
    end
  end

  assign size  = cnt;
  assign full  = (cnt == 5'd16);
  assign empty = (cnt == 5'd0);

endmodule
